// File: rtl/conv10_pkg.sv
// conv10 scheduler shared types and default dimensions.
package conv10_pkg;

  localparam int unsigned WOUT_DEF = 8;
  localparam int unsigned CHIN_DEF = 736;
  localparam int unsigned NPIX_DEF = WOUT_DEF * WOUT_DEF;

  typedef enum logic [2:0] {
    StIdle,
    StRun1,
    StDrain1,
    StRun2,
    StDrain2,
    StDone
  } state_e;

  // Group select: 0 = conv10_1, 1 = conv10_2
  typedef logic grp_t;

endpackage

// File: rtl/conv10_addr_gen.sv
// conv10 ifm address generator: channel/pixel counters and pix*CHIN+ch address.
module conv10_addr_gen #(
  parameter int unsigned CHIN   = 4,
  parameter int unsigned NPIX   = 4,
  parameter int unsigned IFM_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              clr,
  output logic              wrap_o,
  output logic [IFM_AW-1:0] ifm_addr_o
);

  localparam int unsigned CW = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int unsigned PW = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic [CW-1:0] ch_q;
  logic [PW-1:0] pix_q;

  assign wrap_o = (ch_q == CW'(CHIN - 1));

  // Advance one channel per issued read; last channel of a pixel steps the pixel
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ch_q  <= '0;
      pix_q <= '0;
    end else if (adv) begin
      if (wrap_o) begin
        ch_q  <= '0;
        pix_q <= (pix_q == PW'(NPIX - 1)) ? '0 : pix_q + PW'(1);
      end else begin
        ch_q <= ch_q + CW'(1);
      end
    end
  end

  assign ifm_addr_o = IFM_AW'(pix_q) * IFM_AW'(CHIN) + IFM_AW'(ch_q);

endmodule

// File: rtl/conv10_sched.sv
// conv10 array sequencer: runs group 1 then group 2 over all output pixels.
// Optional build macro CONV10_SCHED_PERF_EN adds stall/drain cycle counters.
module conv10_sched
  import conv10_pkg::*;
#(
  parameter int unsigned WOUT      = WOUT_DEF,
  parameter int unsigned CHIN      = CHIN_DEF,
  parameter int unsigned DRAIN_MAX = 16,
  localparam int unsigned NPIX     = WOUT * WOUT,
  localparam int unsigned IFM_AW   = $clog2(NPIX * CHIN),
  localparam int unsigned OFM_AW   = $clog2(2 * NPIX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ofm_ready_i,
  input  logic              sample_i,
  output logic              conv10_1_en_o,
  output logic              conv10_2_en_o,
  output logic [IFM_AW-1:0] ifm_addr_o,
  output logic              ifm_rd_o,
  output logic              ofm_we_o,
  output logic [OFM_AW-1:0] ofm_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef CONV10_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       drain_cnt_o
`endif
);

  localparam int unsigned SW = $clog2(NPIX + 1);
  localparam int unsigned DW = $clog2(DRAIN_MAX + 2);
  localparam logic [IFM_AW-1:0] LastAddr = IFM_AW'(NPIX * CHIN - 1);

  state_e        state_q, state_d;
  logic          en1_q, en1_d, en2_q, en2_d;
  logic [SW-1:0] smp_q, smp_d, smp_nxt;
  grp_t          grp_q, grp_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          err_q, err_d;
  logic          issue, wrap, last_issue, clr;
  logic          in_run, in_drain, smp_ok, hold_ok;

  assign issue      = en1_q | en2_q;
  assign last_issue = issue && (ifm_addr_o == LastAddr);
  assign in_run     = (state_q == StRun1) || (state_q == StRun2);
  assign in_drain   = (state_q == StDrain1) || (state_q == StDrain2);
  assign smp_ok     = sample_i && (in_run || in_drain) && (smp_q != SW'(NPIX));
  assign smp_nxt    = smp_q + SW'(smp_ok);
  // Next cycle sits on a pixel boundary unless mid-pixel; stalled cycles are always at ch 0
  assign hold_ok    = (issue && !wrap) || ofm_ready_i;

  conv10_addr_gen #(
    .CHIN   (CHIN),
    .NPIX   (NPIX),
    .IFM_AW (IFM_AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .adv        (issue),
    .clr        (clr),
    .wrap_o     (wrap),
    .ifm_addr_o (ifm_addr_o)
  );

  // Next-state, registered-enable and bookkeeping decode
  always_comb begin
    state_d = state_q;
    en1_d   = 1'b0;
    en2_d   = 1'b0;
    grp_d   = grp_q;
    smp_d   = smp_nxt;
    dcnt_d  = '0;
    err_d   = err_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun1;
          clr     = 1'b1;
          smp_d   = '0;
          grp_d   = 1'b0;
          en1_d   = ofm_ready_i;
        end
      end
      StRun1: begin
        if (last_issue) state_d = StDrain1;
        else            en1_d   = hold_ok;
      end
      StDrain1: begin
        dcnt_d = dcnt_q + DW'(dcnt_q != '1);
        // Group mux switches only once every group-1 result has landed
        if (smp_nxt == SW'(NPIX)) begin
          state_d = StRun2;
          clr     = 1'b1;
          smp_d   = '0;
          grp_d   = 1'b1;
          en2_d   = ofm_ready_i;
        end
      end
      StRun2: begin
        if (last_issue) state_d = StDrain2;
        else            en2_d   = hold_ok;
      end
      StDrain2: begin
        dcnt_d = dcnt_q + DW'(dcnt_q != '1);
        if (smp_nxt == SW'(NPIX)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        smp_d   = '0;
        grp_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (start_i && (state_q != StIdle)) err_d = 1'b1;
    if (sample_i && !smp_ok)            err_d = 1'b1;
    if (in_drain && (dcnt_q >= DW'(DRAIN_MAX))) err_d = 1'b1;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      smp_q   <= '0;
      grp_q   <= 1'b0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      smp_q   <= smp_d;
      grp_q   <= grp_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  assign conv10_1_en_o = en1_q;
  assign conv10_2_en_o = en2_q;
  assign ifm_rd_o      = issue;
  assign ofm_we_o      = smp_ok;
  assign ofm_addr_o    = OFM_AW'(grp_q) * OFM_AW'(NPIX) + OFM_AW'(smp_q);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign err_o         = err_q;

`ifdef CONV10_SCHED_PERF_EN
  logic [31:0] stall_q, drain_q;

  // Saturating stall/drain cycle counters, restarted by any start_i
  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      if (in_run && !issue && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (in_drain && (drain_q != '1))         drain_q <= drain_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
  assign drain_cnt_o = drain_q;
`endif

endmodule

// File: tb/tb_conv10_sched.sv
// Directed bench for conv10_sched (WOUT=2, CHIN=4, DRAIN_MAX=16) with a simple array model.
module tb_conv10_sched;

  localparam int unsigned WOUT   = 2;
  localparam int unsigned CHIN   = 4;
  localparam int unsigned NPIX   = WOUT * WOUT;
  localparam int unsigned IFM_AW = $clog2(NPIX * CHIN);
  localparam int unsigned OFM_AW = $clog2(2 * NPIX);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              ofm_ready_i = 1'b1;
  logic              sample_i = 1'b0;
  logic              c1, c2, rd, we, busy, done, err;
  logic [IFM_AW-1:0] ifm_addr;
  logic [OFM_AW-1:0] ofm_addr;
`ifdef CONV10_SCHED_PERF_EN
  logic [31:0]       stall_cnt, drain_cnt;
`endif

  conv10_sched #(
    .WOUT      (WOUT),
    .CHIN      (CHIN),
    .DRAIN_MAX (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .ofm_ready_i   (ofm_ready_i),
    .sample_i      (sample_i),
    .conv10_1_en_o (c1),
    .conv10_2_en_o (c2),
    .ifm_addr_o    (ifm_addr),
    .ifm_rd_o      (rd),
    .ofm_we_o      (we),
    .ofm_addr_o    (ofm_addr),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
`ifdef CONV10_SCHED_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .drain_cnt_o   (drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int g1_addr[$];
  int g2_addr[$];
  int wr_log[$];
  int smp_at[$];
  int done_cnt, both_hi, rd_bad, gap, gap_bad, wr_at_g2, start_cyc, g1_first;
  bit start_req, force_smp, bp_arm, drop_last, dup_arm;
  int bp_left;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Index of first entry differing from 0,1,2,...; -1 when the whole list is in order
  function automatic int seq_bad(input int q[$]);
    for (int i = 0; i < q.size(); i++) if (q[i] != i) return i;
    return -1;
  endfunction

  // One clock: observe registered outputs, model the array, drive inputs, observe writes
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (c1 && c2) both_hi++;
    if (rd != (c1 | c2)) rd_bad++;
    if (c1) begin
      if (g1_first < 0) g1_first = cyc;
      g1_addr.push_back(int'(ifm_addr));
    end
    if (c2) begin
      if (wr_at_g2 < 0) wr_at_g2 = wr_log.size();
      g2_addr.push_back(int'(ifm_addr));
    end
    if ((c1 || c2) && (int'(ifm_addr) % CHIN == CHIN - 1) &&
        !(drop_last && c2 && int'(ifm_addr) == NPIX * CHIN - 1))
      smp_at.push_back(cyc + 4);
    if (done) done_cnt++;
    if (dup_arm && g1_addr.size() == 6) begin
      start_req = 1'b1;
      dup_arm   = 1'b0;
    end
    start_i   = start_req;
    start_req = 1'b0;
    if (bp_arm && c1 && int'(ifm_addr) == 3) begin
      bp_left = 5;
      bp_arm  = 1'b0;
    end
    ofm_ready_i = (bp_left == 0);
    if (bp_left > 0) bp_left--;
    sample_i  = force_smp;
    force_smp = 1'b0;
    if (smp_at.size() > 0 && smp_at[0] == cyc) begin
      void'(smp_at.pop_front());
      sample_i = 1'b1;
    end
    #1;
    if (we) wr_log.push_back(int'(ofm_addr));
    if (busy && !c1 && !c2 && g1_addr.size() > 0 && g1_addr.size() < 16) begin
      gap++;
      if (int'(ifm_addr) != 4) gap_bad++;
    end
  endtask

  task automatic clear_logs();
    g1_addr.delete();
    g2_addr.delete();
    wr_log.delete();
    done_cnt = 0; both_hi = 0; rd_bad = 0; gap = 0; gap_bad = 0;
    wr_at_g2 = -1; g1_first = -1; start_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smp_at.delete();
    force_smp = 0; start_req = 0; bp_arm = 0; bp_left = 0; drop_last = 0; dup_arm = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_pass();
    clear_logs();
    start_req = 1'b1;
    start_cyc = cyc + 1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, int'(done_cnt != d0), 1);
  endtask

  initial begin
    clear_logs();
    do_reset();
    check("reset_outputs", int'({c1, c2, ifm_addr, rd, we, ofm_addr, busy, done, err}), 0);

    // Nominal pass
    start_pass();
    run_until_done("nom", 200);
    tick();
    tick();
    check("nom_latency", g1_first - start_cyc, 1);
    check("nom_g1_cnt", g1_addr.size(), 16);
    check("nom_g1_seq", seq_bad(g1_addr), -1);
    check("nom_g2_cnt", g2_addr.size(), 16);
    check("nom_g2_seq", seq_bad(g2_addr), -1);
    check("nom_wr_cnt", wr_log.size(), 8);
    check("nom_wr_seq", seq_bad(wr_log), -1);
    check("nom_done_once", done_cnt, 1);
    check("nom_err", int'(err), 0);
    check("nom_both_hi", both_hi, 0);
    check("nom_g2_after_4wr", wr_at_g2, 4);
    check("nom_no_gap", gap, 0);
    check("nom_rd_match", rd_bad, 0);
    check("nom_idle_busy", int'(busy), 0);
`ifdef CONV10_SCHED_PERF_EN
    check("nom_stall_cnt", int'(stall_cnt), 0);
    check("nom_drain_cnt", int'(drain_cnt), 8);
`endif

    // Backpressure at the pixel-1 boundary
    start_pass();
    bp_arm = 1'b1;
    run_until_done("bp", 200);
    tick();
    check("bp_gap_len", gap, 5);
    check("bp_gap_addr_held", gap_bad, 0);
    check("bp_g1_seq", seq_bad(g1_addr), -1);
    check("bp_g1_cnt", g1_addr.size(), 16);
    check("bp_wr_seq", seq_bad(wr_log), -1);
    check("bp_done_once", done_cnt, 1);
    check("bp_err", int'(err), 0);
`ifdef CONV10_SCHED_PERF_EN
    check("bp_stall_cnt", int'(stall_cnt), 5);
`endif

    // Sample while idle: no write, error flag sets
    clear_logs();
    force_smp = 1'b1;
    tick();
    tick();
    check("idle_smp_no_we", wr_log.size(), 0);
    check("idle_smp_err", int'(err), 1);

    // Start during RUN1 is ignored but flagged
    do_reset();
    check("rst_clears_err", int'(err), 0);
    start_pass();
    dup_arm = 1'b1;
    run_until_done("dup", 200);
    tick();
    check("dup_err", int'(err), 1);
    check("dup_g1_seq", seq_bad(g1_addr), -1);
    check("dup_g2_cnt", g2_addr.size(), 16);
    check("dup_wr_seq", seq_bad(wr_log), -1);
    check("dup_wr_cnt", wr_log.size(), 8);
    check("dup_done_once", done_cnt, 1);

    // Reset in RUN2 at address 9
    do_reset();
    start_pass();
    begin
      int n = 0;
      while (!(c2 && int'(ifm_addr) == 9) && n < 200) begin
        tick();
        n++;
      end
      check("rst_reach_addr9", int'(c2 && int'(ifm_addr) == 9), 1);
    end
    rst = 1'b1;
    smp_at.delete();
    tick();
    check("rst_mid_outputs", int'({c1, c2, ifm_addr, rd, we, ofm_addr, busy, done, err}), 0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) tick();
    check("rst_no_done", done_cnt, 0);
    start_pass();
    run_until_done("restart", 200);
    check("restart_latency", g1_first - start_cyc, 1);
    check("restart_g1_seq", seq_bad(g1_addr), -1);
    check("restart_err", int'(err), 0);

    // Drain watchdog: withhold the final group-2 sample
    tick();
    start_pass();
    drop_last = 1'b1;
    begin
      int n = 0;
      while (g2_addr.size() < 16 && n < 200) begin
        tick();
        n++;
      end
    end
    check("wd_g2_cnt", g2_addr.size(), 16);
    repeat (17) tick();
    check("wd_err_not_yet", int'(err), 0);
    tick();
    check("wd_err_set", int'(err), 1);
    check("wd_still_busy", int'(busy), 1);
    force_smp = 1'b1;
    tick();
    check("wd_late_we", int'(we), 1);
    check("wd_late_addr", int'(ofm_addr), 7);
    run_until_done("wd", 10);
    check("wd_done_once", done_cnt, 1);
    check("wd_err_sticky", int'(err), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv10_sched.md
Name: conv10_sched

Overview:
- Sequencer for the shared 512-MAC conv10 array, which is time-shared between the conv10_1 and conv10_2 groups.
- Runs group 1 and then group 2 over all WOUT*WOUT output pixels, streaming CHIN input channels per pixel.
- Drives the array's group enables and the input-feature-map read address.
- Counts the array's sample strobes and produces the output-RAM write address and write enable.
- Stalls only at pixel boundaries when the downstream buffer is not ready.

Parameters:
- WOUT, 8, output spatial dimension; pixels per group = WOUT*WOUT.
- CHIN, 736, input channels accumulated per pixel (kernel is 1x1).
- DRAIN_MAX, 16, watchdog limit in cycles for the DRAIN states.
- Derived: NPIX = WOUT*WOUT.
- Derived: IFM_AW = $clog2(NPIX*CHIN).
- Derived: OFM_AW = $clog2(2*NPIX).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle pulse; starts a full conv10 pass
- ofm_ready_i  in  1  downstream can absorb one more output pixel
- sample_i  in  1  array output-valid strobe, one pulse per completed pixel
- conv10_1_en_o  in/out: out  1  array enable, group 1
- conv10_2_en_o  out  1  array enable, group 2
- ifm_addr_o  out  IFM_AW  ifm read address = pixel*CHIN + channel
- ifm_rd_o  out  1  ifm read strobe; equals conv10_1_en_o | conv10_2_en_o
- ofm_we_o  out  1  output write enable
- ofm_addr_o  out  OFM_AW  output write address = grp*NPIX + sample count
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  single-cycle pulse at pass completion
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; all counters 0. Reset mid-pass aborts immediately: enables drop on the next edge and no done_o is produced.
- FSM states: IDLE, RUN1, DRAIN1, RUN2, DRAIN2, DONE.
- IDLE -> RUN1 on start_i. start_i in any other state is ignored and sets err_o.
- RUN (either group), per cycle:
  - Assert the group's enable; ifm_addr_o = pix_cnt*CHIN + ch_cnt; ch_cnt increments.
  - When ch_cnt == CHIN-1: ch_cnt wraps to 0 and pix_cnt increments.
  - At a pixel boundary (ch_cnt == 0), the enable is held low while ofm_ready_i = 0. Counters freeze, the address is held, and the array pauses cleanly.
  - The last channel of pixel NPIX-1 moves the FSM to the matching DRAIN state.
- Enables: registered outputs, never both high, driven from the FSM state only.
- DRAIN1 -> RUN2 once smp_cnt == NPIX. DRAIN1 keeps both enables low so the array's group mux is not switched while results are in flight. On leaving DRAIN1, pix_cnt and smp_cnt reset to 0 and grp becomes 1.
- DRAIN2 -> DONE once smp_cnt == NPIX.
- DONE: pulse done_o for one cycle, then return to IDLE.
- sample_i in RUN/DRAIN:
  - Same cycle: ofm_we_o = 1, ofm_addr_o = grp*NPIX + smp_cnt (combinational).
  - Next edge: smp_cnt increments.
- sample_i in IDLE or DONE, or when smp_cnt == NPIX: ignored (no write) and sets err_o.
- Simultaneous last-channel issue and sample_i: both are handled in the same cycle; the state transition uses the post-increment smp_cnt.
- Watchdog: more than DRAIN_MAX cycles in a DRAIN state sets err_o. The FSM keeps waiting; only rst clears it.
- err_o clears only on rst.
- Timing:
  - Issue latency: start_i to first enable is 1 cycle.
  - Throughput with ofm_ready_i held high: one channel per cycle, no bubbles between pixels.
  - Exactly 2*NPIX*CHIN enable cycles per pass.

Optional Feature:
- Macro CONV10_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cnt_o[31:0], counting cycles spent stalled at a pixel boundary in RUN1/RUN2 due to ofm_ready_i = 0.
  - Adds output drain_cnt_o[31:0], counting cycles spent in DRAIN1/DRAIN2.
  - Both clear on rst and on start_i, and saturate at all-ones.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package conv10_pkg holds:
  - the state enum (IDLE..DONE);
  - the WOUT, CHIN and NPIX defaults;
  - the grp_t typedef (1-bit group select).
- Sub-module conv10_addr_gen: ch_cnt/pix_cnt counters plus the ifm address multiply-add, with inputs adv, clr and wrap_o. The FSM and sample counter stay in conv10_sched.

Test Plan (WOUT=2, CHIN=4, DRAIN_MAX=16):
- Nominal pass:
  - Stimulus: start_i pulse, ofm_ready_i = 1; bench models the array with sample_i 4 cycles after each pixel's last channel.
  - Required: conv10_1_en_o high for 16 cycles with ifm_addr_o 0..15; then conv10_2_en_o high for 16 cycles with 0..15; ofm_addr_o 0..7 in order; done_o once; err_o = 0.
- Backpressure:
  - Stimulus: drop ofm_ready_i for 5 cycles at the pixel-1 boundary.
  - Required: enable low for exactly 5 cycles, ifm_addr_o held at 4, resumes at 4,5,6,7; with PERF_EN, stall_cnt_o = 5.
- Group isolation:
  - Check: no cycle has both enables high.
  - Check: conv10_2_en_o does not rise until the 4th sample of group 1 has been written (ofm_addr_o = 3).
- Protocol errors:
  - Stimulus: sample_i while in IDLE.
  - Required: no ofm_we_o, err_o = 1.
  - Stimulus: start_i during RUN1.
  - Required: ignored, err_o = 1, pass completes normally.
- Reset mid-pass:
  - Stimulus: assert rst during RUN2 at ifm_addr_o = 9.
  - Required: all outputs 0 the next cycle, no done_o; a fresh start_i restarts at group 1, address 0.
- Drain watchdog:
  - Stimulus: withhold the final group-2 sample.
  - Required: err_o sets after 17 cycles in DRAIN2; a late sample_i still writes ofm_addr_o = 7 and done_o pulses.
